// File: rtl/dsp_post_accum.sv
// DSP48A1 post-adder/accumulator: P = Z +/- (X + CIN), optional saturation via DSP_POST_ACCUM_SAT_EN.
// Latency 1 cycle (PREG=1) or 0 (PREG=0); no backpressure, CEP=0 freezes all state.
module dsp_post_accum #(
    parameter int PREG       = 1,
    parameter int OVF_STICKY = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CEP,
    input  logic        VALID_IN,
    input  logic [35:0] M,
    input  logic [47:0] C,
    input  logic [47:0] PCIN,
    input  logic [3:0]  OPMODE,
    input  logic        SUB,
    input  logic        CIN,
    input  logic        CLR_OVF,
    output logic [47:0] P,
    output logic [47:0] PCOUT,
    output logic        CARRYOUT,
    output logic        VALID_OUT,
    output logic        OVF
);

    logic [47:0] p_q;
    logic        carry_q;
    logic        valid_q;
    logic        ovf_q;

    logic [47:0] fb;
    logic [47:0] x_sel;
    logic [47:0] z_sel;
    logic [48:0] sum;
    logic        x_sign_eff;
    logic        ovf_c;
    logic [47:0] p_next;
    logic        upd;

    // Without the P register there is nothing to feed back, so feedback reads as zero.
    assign fb  = (PREG != 0) ? p_q : 48'd0;
    assign upd = CEP && VALID_IN;

    always_comb begin
        x_sel = 48'd0;
        z_sel = 48'd0;
        case (OPMODE[1:0])
            2'd1:    x_sel = {{12{M[35]}}, M};
            2'd2:    x_sel = fb;
            default: x_sel = 48'd0;
        endcase
        case (OPMODE[3:2])
            2'd1:    z_sel = PCIN;
            2'd2:    z_sel = fb;
            2'd3:    z_sel = C;
            default: z_sel = 48'd0;
        endcase
    end

    always_comb begin
        sum = 49'd0;
        if (SUB)
            sum = {1'b0, z_sel} - ({1'b0, x_sel} + {48'd0, CIN});
        else
            sum = {1'b0, z_sel} + {1'b0, x_sel} + {48'd0, CIN};
    end

    // Subtraction is Z + ~X + !CIN, so the effective X sign is inverted.
    assign x_sign_eff = SUB ? ~x_sel[47] : x_sel[47];
    assign ovf_c      = (z_sel[47] == x_sign_eff) && (sum[47] != z_sel[47]);

    always_comb begin
        p_next = sum[47:0];
`ifdef DSP_POST_ACCUM_SAT_EN
        if (ovf_c)
            p_next = z_sel[47] ? 48'h8000_0000_0000 : 48'h7FFF_FFFF_FFFF;
`endif
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p_q     <= 48'd0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (CEP) begin
            valid_q <= VALID_IN;
            if (VALID_IN) begin
                p_q     <= p_next;
                carry_q <= sum[48];
            end
            // Set beats clear; the non-sticky flavour tracks each accepted result.
            if (VALID_IN && ovf_c)
                ovf_q <= 1'b1;
            else if (CLR_OVF)
                ovf_q <= 1'b0;
            else if ((OVF_STICKY == 0) && VALID_IN)
                ovf_q <= 1'b0;
        end
    end

    assign P         = (PREG != 0) ? p_q     : p_next;
    assign PCOUT     = P;
    assign CARRYOUT  = (PREG != 0) ? carry_q : sum[48];
    assign VALID_OUT = (PREG != 0) ? valid_q : VALID_IN;
    assign OVF       = (PREG != 0) ? ovf_q   : ovf_c;

endmodule

// File: tb/tb_dsp_post_accum.sv
// Directed bench for dsp_post_accum: registered instance plus a PREG=0 bypass instance.
module tb_dsp_post_accum;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        CEP = 1'b0;
    logic        VALID_IN = 1'b0;
    logic [35:0] M = '0;
    logic [47:0] C = '0;
    logic [47:0] PCIN = '0;
    logic [3:0]  OPMODE = '0;
    logic        SUB = 1'b0;
    logic        CIN = 1'b0;
    logic        CLR_OVF = 1'b0;

    logic [47:0] p_r, pc_r, p_b, pc_b;
    logic        co_r, vo_r, ovf_r, co_b, vo_b, ovf_b;

    int checks = 0;
    int errors = 0;

    logic [47:0] exp_pos_ovf;
    logic [47:0] exp_neg_ovf;

    dsp_post_accum #(.PREG(1), .OVF_STICKY(1)) u_reg (
        .CLK(CLK), .RST_N(RST_N), .CEP(CEP), .VALID_IN(VALID_IN), .M(M), .C(C),
        .PCIN(PCIN), .OPMODE(OPMODE), .SUB(SUB), .CIN(CIN), .CLR_OVF(CLR_OVF),
        .P(p_r), .PCOUT(pc_r), .CARRYOUT(co_r), .VALID_OUT(vo_r), .OVF(ovf_r)
    );

    dsp_post_accum #(.PREG(0), .OVF_STICKY(1)) u_byp (
        .CLK(CLK), .RST_N(RST_N), .CEP(CEP), .VALID_IN(VALID_IN), .M(M), .C(C),
        .PCIN(PCIN), .OPMODE(OPMODE), .SUB(SUB), .CIN(CIN), .CLR_OVF(CLR_OVF),
        .P(p_b), .PCOUT(pc_b), .CARRYOUT(co_b), .VALID_OUT(vo_b), .OVF(ovf_b)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
`ifdef DSP_POST_ACCUM_SAT_EN
        exp_pos_ovf = 48'h7FFF_FFFF_FFFF;
        exp_neg_ovf = 48'h8000_0000_0000;
`else
        exp_pos_ovf = 48'h8000_0000_0000;
        exp_neg_ovf = 48'h7FFF_FFFF_FFFF;
`endif
        #2 RST_N = 1'b0;
        #2;
        chk("rst_p", p_r, 48'd0);
        chk("rst_co", {47'd0, co_r}, 48'd0);
        chk("rst_vo", {47'd0, vo_r}, 48'd0);
        chk("rst_ovf", {47'd0, ovf_r}, 48'd0);
        #4 RST_N = 1'b1;

        // Accumulate M = 5, 7, -3
        CEP = 1'b1; VALID_IN = 1'b1; OPMODE = 4'b1001;
        M = 36'd5;           step(); chk("acc1", p_r, 48'd5);  chk("acc1_vo", {47'd0, vo_r}, 48'd1);
        M = 36'd7;           step(); chk("acc2", p_r, 48'd12); chk("acc2_pcout", pc_r, 48'd12);
        M = -36'sd3;         step(); chk("acc3", p_r, 48'd9);  chk("acc3_vo", {47'd0, vo_r}, 48'd1);

        // Stall for three cycles with M changing
        CEP = 1'b0;
        for (int i = 0; i < 3; i++) begin
            M = 36'd100 + 36'(i);
            step();
            chk("stall_p", p_r, 48'd9);
            chk("stall_vo", {47'd0, vo_r}, 48'd1);
            chk("stall_ovf", {47'd0, ovf_r}, 48'd0);
        end
        CEP = 1'b1; M = 36'd1; step(); chk("resume", p_r, 48'd10);

        // Positive overflow
        OPMODE = 4'b1100; C = 48'h7FFF_FFFF_FFFF; step(); chk("load_max", p_r, 48'h7FFF_FFFF_FFFF);
        OPMODE = 4'b1001; M = 36'd1; step();
        chk("povf_p", p_r, exp_pos_ovf);
        chk("povf_flag", {47'd0, ovf_r}, 48'd1);
        chk("povf_co", {47'd0, co_r}, 48'd0);
        M = 36'd0; step(); chk("ovf_sticky", {47'd0, ovf_r}, 48'd1);
        CEP = 1'b0; CLR_OVF = 1'b1; step(); chk("clr_no_cep", {47'd0, ovf_r}, 48'd1);
        CEP = 1'b1; step(); chk("clr_cep", {47'd0, ovf_r}, 48'd0);

        // Negative overflow with CLR_OVF in the same cycle: set wins
        OPMODE = 4'b1101; C = 48'h8000_0000_0000; M = -36'sd1; step();
        chk("novf_p", p_r, exp_neg_ovf);
        chk("novf_flag", {47'd0, ovf_r}, 48'd1);
        chk("novf_co", {47'd0, co_r}, 48'd1);
        CLR_OVF = 1'b0; OPMODE = 4'b1100; C = 48'h1234; step();
        chk("load_1234", p_r, 48'h1234);

        // Asynchronous reset mid-accumulation
        OPMODE = 4'b1001; M = 36'd1;
        #2 RST_N = 1'b0;
        #1;
        chk("arst_p", p_r, 48'd0);
        chk("arst_pcout", pc_r, 48'd0);
        chk("arst_co", {47'd0, co_r}, 48'd0);
        chk("arst_vo", {47'd0, vo_r}, 48'd0);
        chk("arst_ovf", {47'd0, ovf_r}, 48'd0);
        #2 RST_N = 1'b1;
        M = 36'd3; step(); chk("post_rst", p_r, 48'd3);

        // Subtract with borrow
        OPMODE = 4'b1101; SUB = 1'b1; C = 48'd10; M = 36'd3; CIN = 1'b1; step();
        chk("sub1_p", p_r, 48'd6);
        chk("sub1_co", {47'd0, co_r}, 48'd0);
        C = 48'd2; CIN = 1'b0; step();
        chk("sub2_p", p_r, 48'hFFFF_FFFF_FFFF);
        chk("sub2_co", {47'd0, co_r}, 48'd1);
        chk("sub2_ovf", {47'd0, ovf_r}, 48'd0);

        // VALID_IN low: P holds, VALID_OUT drops
        VALID_IN = 1'b0; C = 48'd50; step();
        chk("nv_p", p_r, 48'hFFFF_FFFF_FFFF);
        chk("nv_vo", {47'd0, vo_r}, 48'd0);

        // Combinational bypass
        VALID_IN = 1'b1; SUB = 1'b0; CIN = 1'b0;
        OPMODE = 4'b0101; PCIN = 48'd100; M = -36'sd1; #1;
        chk("byp_p", p_b, 48'd99);
        chk("byp_pcout", pc_b, 48'd99);
        chk("byp_vo", {47'd0, vo_b}, 48'd1);
        chk("byp_ovf", {47'd0, ovf_b}, 48'd0);
        OPMODE = 4'b1010; #1;
        chk("byp_fb", p_b, 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_post_accum.md
# dsp_post_accum

Post-adder/accumulator stage of the DSP48A1 slice. It consumes the 36-bit product from the multiplier-output pipeline register, along with the C operand and the cascade input. It computes `Z ± (X + CIN)` over 48 bits and registers the result as P with carry-out, a valid flag and a sticky signed-overflow flag. It is the final arithmetic stage: P feeds the slice output and PCOUT drives the next slice's PCIN.

## Interface
Parameters:
- `PREG`, 1: 1 = P/CARRYOUT/VALID_OUT registered; 0 = combinational bypass.
- `OVF_STICKY`, 1: 1 = OVF holds until `CLR_OVF` or reset; 0 = OVF reflects the current result only.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `CEP` in 1: clock enable for P, CARRYOUT, VALID_OUT and OVF.
- `VALID_IN` in 1: operands valid this cycle.
- `M` in 36: signed product from the multiplier register.
- `C` in 48: C operand.
- `PCIN` in 48: cascade input from the previous slice.
- `OPMODE` in 4: [1:0] selects X, [3:2] selects Z.
- `SUB` in 1: 0 = add, 1 = subtract.
- `CIN` in 1: carry-in.
- `CLR_OVF` in 1: synchronous clear of OVF, gated by CEP.
- `P` out 48: result.
- `PCOUT` out 48: cascade output, always equal to P.
- `CARRYOUT` out 1: carry/borrow out of bit 47.
- `VALID_OUT` out 1: P holds a valid result.
- `OVF` out 1: signed overflow flag.

## Operation
- X mux:
  - 0 → 0
  - 1 → M sign-extended to 48 bits
  - 2 → P (feedback)
  - 3 → reserved, yields 0
- Z mux:
  - 0 → 0
  - 1 → PCIN
  - 2 → P (feedback)
  - 3 → C
- Arithmetic on 49-bit zero-extended operands:
  - SUB=0: `R = Z + X + CIN`
  - SUB=1: `R = Z − (X + CIN)`
  - P = R[47:0]; CARRYOUT = R[48] (a borrow when subtracting).
- Signed overflow is raised when the true two's-complement result lies outside [−2^47, 2^47−1]. Detect it from the sign bits of Z, the effective X term and R[47].
- Update is gated by `CEP && VALID_IN`:
  - When set, P and CARRYOUT load the new values.
  - When clear, P and CARRYOUT hold.
- `VALID_OUT` loads `VALID_IN` on every CEP=1 edge and holds when CEP=0.
- OVF:
  - With `OVF_STICKY=1`, it sets on any overflow during an update and clears only on `CLR_OVF` (with CEP=1) or reset.
  - If `CLR_OVF` and an overflow occur in the same cycle, set wins.
- `PREG=0`:
  - All outputs are combinational from the current inputs, and VALID_OUT = VALID_IN.
  - The P feedback selections (X=2, Z=2) have no register to read, so they yield 0.
  - OVF becomes the non-sticky combinational flag.
- Reset (asserted asynchronously at any time, including mid-accumulation): P=0, PCOUT=0, CARRYOUT=0, VALID_OUT=0, OVF=0. The first update after release uses P=0 as feedback.

## Timing
- `PREG=1`: latency is 1 cycle. Operands presented with VALID_IN=1, CEP=1 at edge n appear on P and VALID_OUT after edge n.
- Back-to-back accumulation (X=1, Z=2) sustains one operand per cycle; each result includes all prior accepted M values.
- CEP=0 freezes every register, including VALID_OUT and OVF, regardless of the other inputs.
- Reset release is synchronised externally; the block needs no recovery cycles beyond one clock edge.

## Configuration
- `DSP_POST_ACCUM_SAT_EN`: when defined, a signed overflow makes P load the saturated value instead of the wrapped value:
  - 48'h7FFF_FFFF_FFFF on positive overflow.
  - 48'h8000_0000_0000 on negative overflow.
  - CARRYOUT still reports R[48] and OVF still asserts.
- When undefined, P wraps modulo 2^48.

## Test plan
- Reset: drive RST_N=0 mid-accumulation with P=48'h1234 → P, CARRYOUT, VALID_OUT and OVF go to 0 immediately, without waiting for a clock edge.
- Accumulate: OPMODE=4'b1001, SUB=0, VALID_IN=1 with M=5, 7, −3 on consecutive cycles → P = 5, 12, 9 one cycle after each input; VALID_OUT=1 throughout.
- Subtract with borrow: OPMODE=4'b1101, C=10, M=3, SUB=1, CIN=1 → P=6, CARRYOUT=0. Then C=2, M=3, CIN=0 → P=48'hFFFF_FFFF_FFFF, CARRYOUT=1.
- Stall: while accumulating, CEP=0 for 3 cycles with M changing → P, VALID_OUT and OVF frozen; accumulation resumes correctly once CEP returns to 1.
- Overflow: P=48'h7FFF_FFFF_FFFF, then accumulate M=1:
  - Without the macro → P=48'h8000_0000_0000, OVF=1.
  - With `DSP_POST_ACCUM_SAT_EN` → P=48'h7FFF_FFFF_FFFF, OVF=1.
  - OVF stays 1 until CLR_OVF=1 with CEP=1.
- Cascade and bypass: PREG=0, OPMODE=4'b0101, PCIN=100, M=−1 → P=PCOUT=99 in the same cycle. OPMODE=4'b1010 → P=0.
